// File: rtl/riscv_pkg.sv
// Shared core constants: datapath width, reset vector, instruction size and
// the base opcodes that decode switches on.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, the decode
// handoff and the execute redirect. master = fetch unit, slave = its environment.
interface fetch_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs; flush beats push and pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is left unreset; the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word
// requests, buffers in-order responses and hands {pc, inst} to decode.
module fetch_unit #(
  parameter int unsigned          XLEN     = riscv_pkg::XLEN,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = XLEN'(riscv_pkg::RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  import riscv_pkg::*;

  localparam int unsigned     CW  = $clog2(DEPTH + 1);
  localparam int unsigned     EW  = XLEN + 32;
  localparam logic [XLEN-1:0] INC = XLEN'(INST_BYTES);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            drop;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [EW-1:0]   head;

  // Credit covers both buffered and in-flight words so a response always has a slot.
  assign credit_used = {1'b0, pending} + {1'b0, count};
  assign bus.imem_req_valid = !reset && !bus.redirect_valid
                              && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  assign drop   = bus.imem_rsp_valid && (discard != '0);
  assign push   = bus.imem_rsp_valid && !drop;
  assign pop    = bus.inst_valid && bus.inst_ready;
  assign target = bus.redirect_pc & ~XLEN'(3);

  assign bus.inst_valid = !empty;
  assign {bus.inst_pc, bus.inst_data} = empty ? '0 : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      pending  <= '0;
      discard  <= '0;
    end else begin
      pending <= pending + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        // Every word still outstanding after this cycle belongs to the old stream.
        fetch_pc <= target;
        rsp_pc   <= target;
        discard  <= pending - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + INC;
        if (push)     rsp_pc   <= rsp_pc + INC;
        if (drop)     discard  <= discard - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   ({rsp_pc, bus.imem_rsp_data}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push && !bus.redirect_valid) |-> (!full || pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model
// whose ROM word at byte address a holds a>>2.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [31:0] addr; int rem; } mreq_t;
  typedef struct { logic [31:0] a; int unsigned c; } rlog_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } plog_t;

  mreq_t       mq[$];
  rlog_t       req_log[$];
  plog_t       pop_log[$];
  int          lat = 1;
  int unsigned cyc = 0;
  int unsigned bad_pairs = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Memory model and bus monitor: respond at the falling edge, sample just
  // before the rising edge.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      foreach (mq[i]) mq[i].rem = mq[i].rem - 1;
      if (mq.size() > 0 && mq[0].rem <= 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mq[0].addr >> 2;
        mq.delete(0);
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      #4;
      if (reset) begin
        mq.delete();
        bus.imem_rsp_valid = 1'b0;
      end else begin
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          mq.push_back('{bus.imem_req_addr, lat});
          req_log.push_back('{bus.imem_req_addr, cyc});
        end
        if (bus.inst_valid && bus.inst_ready)
          pop_log.push_back('{bus.inst_pc, bus.inst_data});
        if (bus.inst_valid && bus.inst_data != (bus.inst_pc >> 2))
          bad_pairs++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    req_log.delete();
    pop_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_inst(input string tag, input int unsigned max);
    int unsigned k = 0;
    while (!bus.inst_valid && k < max) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 64'(bus.inst_valid), 64'd1);
  endtask

  initial begin
    reset              = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // 1: reset state, then latency-1 streaming
    lat = 1;
    tick();
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst_data", 64'(bus.inst_data), 64'd0);
    chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(bus.imem_req_addr), 64'd0);
    req_log.delete();
    pop_log.delete();
    reset = 1'b0;
    #1;
    chk("t1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    tick();
    chk("t1_inst_valid_e1", 64'(bus.inst_valid), 64'd0);
    chk("t1_req_addr_e1", 64'(bus.imem_req_addr), 64'h4);
    tick();
    chk("t1_inst_valid_e2", 64'(bus.inst_valid), 64'd1);
    chk("t1_pc0", 64'(bus.inst_pc), 64'h0);
    chk("t1_data0", 64'(bus.inst_data), 64'd0);
    tick();
    chk("t1_pc1", 64'(bus.inst_pc), 64'h4);
    chk("t1_data1", 64'(bus.inst_data), 64'd1);
    tick();
    chk("t1_pc2", 64'(bus.inst_pc), 64'h8);
    chk("t1_data2", 64'(bus.inst_data), 64'd2);
    chk("t1_req0", 64'(req_log[0].a), 64'h0);
    chk("t1_req1", 64'(req_log[1].a), 64'h4);
    chk("t1_req2", 64'(req_log[2].a), 64'h8);
    chk("t1_req_span", 64'(req_log[2].c - req_log[0].c), 64'd2);

    // 2: decode stalled, credit caps in-flight + buffered at 4
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("t2_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("t2_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("t2_head_pc", 64'(bus.inst_pc), 64'h0);
    chk("t2_req_count", 64'(req_log.size()), 64'd4);
    bus.inst_ready = 1'b1;
    repeat (10) tick();
    chk("t2_pop_count", 64'(pop_log.size() >= 5), 64'd1);
    chk("t2_pop0", 64'(pop_log[0].pc), 64'h0);
    chk("t2_pop1", 64'(pop_log[1].pc), 64'h4);
    chk("t2_pop2", 64'(pop_log[2].pc), 64'h8);
    chk("t2_pop3", 64'(pop_log[3].pc), 64'hC);
    chk("t2_pop3_data", 64'(pop_log[3].data), 64'd3);
    chk("t2_pop4", 64'(pop_log[4].pc), 64'h10);
    chk("t2_req4", 64'(req_log[4].a), 64'h10);

    // 3: latency 3, redirect with two requests in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    #1;
    chk("t3_req_blocked", 64'(bus.imem_req_valid), 64'd0);
    chk("t3_inflight", 64'(req_log.size()), 64'd2);
    tick();
    bus.redirect_valid = 1'b0;
    chk("t3_flush", 64'(bus.inst_valid), 64'd0);
    chk("t3_req_addr", 64'(bus.imem_req_addr), 64'h40);
    repeat (3) tick();
    chk("t3_dropped", 64'(bus.inst_valid), 64'd0);
    tick();
    chk("t3_valid", 64'(bus.inst_valid), 64'd1);
    chk("t3_pc", 64'(bus.inst_pc), 64'h40);
    chk("t3_data", 64'(bus.inst_data), 64'h10);
    tick();
    chk("t3_pop0", 64'(pop_log[0].pc), 64'h40);

    // 4: unaligned redirect target
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    tick();
    bus.redirect_valid = 1'b0;
    pop_log.delete();
    chk("t4_req_addr", 64'(bus.imem_req_addr), 64'h40);
    chk("t4_flush", 64'(bus.inst_valid), 64'd0);
    wait_inst("t4", 20);
    chk("t4_pc", 64'(bus.inst_pc), 64'h40);
    chk("t4_data", 64'(bus.inst_data), 64'h10);
    tick();
    chk("t4_pop0", 64'(pop_log[0].pc), 64'h40);

    // 5: redirect coincides with a response, a pop and one more in flight
    lat = 2;
    do_reset();
    repeat (3) tick();
    chk("t5_pre_valid", 64'(bus.inst_valid), 64'd1);
    chk("t5_pre_pc", 64'(bus.inst_pc), 64'h0);
    chk("t5_pre_rsp", 64'(bus.imem_rsp_valid), 64'd1);
    chk("t5_pre_reqs", 64'(req_log.size()), 64'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    tick();
    bus.redirect_valid = 1'b0;
    pop_log.delete();
    chk("t5_flush", 64'(bus.inst_valid), 64'd0);
    chk("t5_req_addr", 64'(bus.imem_req_addr), 64'h80);
    tick();
    chk("t5_stale_dropped", 64'(bus.inst_valid), 64'd0);
    wait_inst("t5", 20);
    chk("t5_pc", 64'(bus.inst_pc), 64'h80);
    chk("t5_data", 64'(bus.inst_data), 64'h20);
    tick();
    chk("t5_pop0", 64'(pop_log[0].pc), 64'h80);

    // 6: reset while three entries are buffered
    lat = 1;
    bus.inst_ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("t6_pre_valid", 64'(bus.inst_valid), 64'd1);
    chk("t6_pre_req_addr", 64'(bus.imem_req_addr), 64'h10);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.inst_valid), 64'd0);
    chk("t6_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("t6_rst_req_addr", 64'(bus.imem_req_addr), 64'h0);
    tick();
    tick();
    reset = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    chk("t6_restart_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("t6_restart_addr", 64'(bus.imem_req_addr), 64'h0);
    tick();
    tick();
    chk("t6_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("t6_inst_pc", 64'(bus.inst_pc), 64'h0);
    tick();
    chk("t6_inst_pc_next", 64'(bus.inst_pc), 64'h4);

    chk("pc_data_pairs", 64'(bad_pairs), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
